// File: rtl/mux_n_a_1_reg_if.sv
// Handshake bundle for the registered N:1 selector: per-source valid/ready/data
// on the input side, one registered word with its source index on the output side.
interface mux_n_a_1_reg_if #(
    parameter int WIDTH    = 8,
    parameter int N_INPUTS = 4
);
    localparam int SEL_W = $clog2(N_INPUTS);

    logic                      mode;
    logic [SEL_W-1:0]          selector;
    logic [N_INPUTS-1:0]       in_valid;
    logic [N_INPUTS*WIDTH-1:0] in_data;
    logic [N_INPUTS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output mode, selector, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, selector, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_n_a_1_reg.sv
// Registered N:1 data selector with explicit-select or round-robin arbitration
// and a one-entry output register that holds its word under back-pressure.
module mux_n_a_1_reg #(
    parameter int WIDTH    = 8,
    parameter int N_INPUTS = 4
) (
    input logic            clk,
    input logic            reset,
    mux_n_a_1_reg_if.slave bus
);
    localparam int SEL_W = $clog2(N_INPUTS);
    localparam int N_PAD = 1 << SEL_W;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] chosen;
    logic             granted;
    logic             load_en;
    logic             xfer;
    logic [SEL_W:0]   rr_res;
    logic [N_PAD-1:0] valid_pad;
    logic [N_PAD-1:0] ready_pad;
    logic [WIDTH-1:0] data_pad [N_PAD];

    // Wrap-around scan from ptr; iterating backwards lets the nearest valid source win.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_INPUTS-1:0] v,
                                               input logic [SEL_W-1:0]    ptr);
        logic [SEL_W:0] res;
        int             j;
        res = '0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_INPUTS) j = j - N_INPUTS;
            if (v[j]) res = {1'b1, SEL_W'(j)};
        end
        return res;
    endfunction

    // Sources are padded to a power of two so an out-of-range selector sees an invalid, zero source.
    always_comb begin
        valid_pad                 = '0;
        valid_pad[N_INPUTS-1:0]   = bus.in_valid;
        data_pad                  = '{default: '0};
        for (int i = 0; i < N_INPUTS; i++) begin
            data_pad[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign rr_res = rr_pick(bus.in_valid, rr_ptr);

    always_comb begin
        if (bus.mode) begin
            chosen  = rr_res[SEL_W-1:0];
            granted = rr_res[SEL_W];
        end else begin
            chosen  = bus.selector;
            granted = valid_pad[bus.selector];
        end
    end

    assign load_en = ~bus.out_valid | bus.out_ready;
    assign xfer    = granted & load_en & ~reset;

    always_comb begin
        ready_pad = '0;
        if (xfer) ready_pad[chosen] = 1'b1;
        bus.in_ready = ready_pad[N_INPUTS-1:0];
    end

    // A fill on the same edge as a drain keeps out_valid high, so there is never a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rr_ptr        <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= data_pad[chosen];
                bus.out_sel   <= chosen;
                if (bus.mode) begin
                    rr_ptr <= (int'(chosen) == N_INPUTS - 1) ? '0 : chosen + SEL_W'(1);
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
